// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- 29-input threshold voter, two-stage pipeline.
//
// Counts the ones in the vote vector {x28..x0}. y0 is 1 when the count is at
// least THRESH. The default THRESH of 15 gives a strict majority of 29.
//
// Pipeline:
//   stage 1 registers four group popcounts (bits 0-7, 8-15, 16-23, 24-28).
//   stage 2 adds the group counts, compares the sum and registers y0.
// A vector sampled with in_valid=1 reaches y0 two clocks later, with
// out_valid=1. A new vector is accepted every cycle. When out_valid=0, y0
// holds its last value.
//
// Parameters:
//   THRESH     number of ones needed for y0=1 (legal range 1..29)
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all pipeline state
//   x0..x28    voter bits, x0 is the LSB of the vote vector
//   in_valid   the vote vector is sampled on this edge
//   y0         registered threshold result
//   out_valid  y0 carries a new result this cycle
//   cnt        registered popcount aligned with y0 (TOP_COUNT_OUT_EN only)
//
// Optional feature macro: TOP_COUNT_OUT_EN (adds the cnt output port).
// ---------------------------------------------------------------------------
module top #(
   parameter int THRESH = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
   input  logic       x8,  x9,  x10, x11, x12, x13, x14, x15,
   input  logic       x16, x17, x18, x19, x20, x21, x22, x23,
   input  logic       x24, x25, x26, x27, x28,
   input  logic       in_valid,
   output logic       y0,
   output logic       out_valid
`ifdef TOP_COUNT_OUT_EN
   ,
   output logic [4:0] cnt
`endif
);

   localparam logic [4:0] THRESH_W = 5'(THRESH);

   logic [28:0]      vec;
   logic [3:0][3:0]  grp_d;      // combinational group popcounts
   logic [3:0][3:0]  grp_q;      // stage-1 registered group popcounts
   logic             valid_q;    // stage-1 valid
   logic [4:0]       sum;        // stage-2 total, 0..29 fits in 5 bits

   assign vec = {x28, x27, x26, x25, x24, x23, x22, x21, x20, x19,
                 x18, x17, x16, x15, x14, x13, x12, x11, x10, x9,
                 x8,  x7,  x6,  x5,  x4,  x3,  x2,  x1,  x0};

   function automatic logic [3:0] pop8(input logic [7:0] b);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s = s + 4'(b[i]);
      return s;
   endfunction

   // NOTE: every signal written in an always_comb gets a value on every path;
   // a signal left unassigned on some path turns into an inferred latch.
   always_comb begin
      grp_d    = '0;
      grp_d[0] = pop8(vec[7:0]);
      grp_d[1] = pop8(vec[15:8]);
      grp_d[2] = pop8(vec[23:16]);
      grp_d[3] = pop8({3'b000, vec[28:24]});
   end

   always_comb begin
      sum = {1'b0, grp_q[0]} + {1'b0, grp_q[1]}
          + {1'b0, grp_q[2]} + {1'b0, grp_q[3]};
   end

   // Stage 1: group popcounts and valid.
   // NOTE: state registers use non-blocking assignments, so every stage
   // samples the value its predecessor held before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data registers are reset along with the valids. Nothing
         // depends on stale data, but this keeps the state deterministic
         // after a reset.
         grp_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) grp_q <= grp_d;
      end
   end

   // Stage 2: compare and register the result. y0 only moves on a valid
   // stage, so it holds its value through idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y0        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= valid_q;
         if (valid_q) y0 <= (sum >= THRESH_W);
      end
   end

`ifdef TOP_COUNT_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt <= '0;
      else if (valid_q) cnt <= sum;
   end
`endif

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top -- scoreboard bench for the 29-input threshold voter.
//
// Three instances share one stimulus: THRESH=15 (default), THRESH=1 and
// THRESH=29. The driver pushes the expected response of every vector, with
// the edge on which it is due, into a queue. A monitor on the falling edge
// pops an entry whenever out_valid is high and compares it. On idle cycles
// the monitor checks that y0 holds its last value.
// ---------------------------------------------------------------------------
module tb_top;

   typedef struct {
      int         due;
      logic       y15;
      logic       y1;
      logic       y29;
      logic [4:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [28:0] vec;
   logic        y_15, ov_15, y_1, ov_1, y_29, ov_29;
`ifdef TOP_COUNT_OUT_EN
   logic [4:0]  cnt_15, cnt_1, cnt_29;
`endif

   exp_t        q[$];
   exp_t        hold;
   int          edge_cnt = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   top #(.THRESH(15)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .x0(vec[0]),   .x1(vec[1]),   .x2(vec[2]),   .x3(vec[3]),   .x4(vec[4]),
      .x5(vec[5]),   .x6(vec[6]),   .x7(vec[7]),   .x8(vec[8]),   .x9(vec[9]),
      .x10(vec[10]), .x11(vec[11]), .x12(vec[12]), .x13(vec[13]), .x14(vec[14]),
      .x15(vec[15]), .x16(vec[16]), .x17(vec[17]), .x18(vec[18]), .x19(vec[19]),
      .x20(vec[20]), .x21(vec[21]), .x22(vec[22]), .x23(vec[23]), .x24(vec[24]),
      .x25(vec[25]), .x26(vec[26]), .x27(vec[27]), .x28(vec[28]),
      .in_valid(in_valid), .y0(y_15), .out_valid(ov_15)
`ifdef TOP_COUNT_OUT_EN
      , .cnt(cnt_15)
`endif
   );

   top #(.THRESH(1)) u_t1 (
      .clk(clk), .rst_n(rst_n),
      .x0(vec[0]),   .x1(vec[1]),   .x2(vec[2]),   .x3(vec[3]),   .x4(vec[4]),
      .x5(vec[5]),   .x6(vec[6]),   .x7(vec[7]),   .x8(vec[8]),   .x9(vec[9]),
      .x10(vec[10]), .x11(vec[11]), .x12(vec[12]), .x13(vec[13]), .x14(vec[14]),
      .x15(vec[15]), .x16(vec[16]), .x17(vec[17]), .x18(vec[18]), .x19(vec[19]),
      .x20(vec[20]), .x21(vec[21]), .x22(vec[22]), .x23(vec[23]), .x24(vec[24]),
      .x25(vec[25]), .x26(vec[26]), .x27(vec[27]), .x28(vec[28]),
      .in_valid(in_valid), .y0(y_1), .out_valid(ov_1)
`ifdef TOP_COUNT_OUT_EN
      , .cnt(cnt_1)
`endif
   );

   top #(.THRESH(29)) u_t29 (
      .clk(clk), .rst_n(rst_n),
      .x0(vec[0]),   .x1(vec[1]),   .x2(vec[2]),   .x3(vec[3]),   .x4(vec[4]),
      .x5(vec[5]),   .x6(vec[6]),   .x7(vec[7]),   .x8(vec[8]),   .x9(vec[9]),
      .x10(vec[10]), .x11(vec[11]), .x12(vec[12]), .x13(vec[13]), .x14(vec[14]),
      .x15(vec[15]), .x16(vec[16]), .x17(vec[17]), .x18(vec[18]), .x19(vec[19]),
      .x20(vec[20]), .x21(vec[21]), .x22(vec[22]), .x23(vec[23]), .x24(vec[24]),
      .x25(vec[25]), .x26(vec[26]), .x27(vec[27]), .x28(vec[28]),
      .in_valid(in_valid), .y0(y_29), .out_valid(ov_29)
`ifdef TOP_COUNT_OUT_EN
      , .cnt(cnt_29)
`endif
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected response for a vector holding c ones, due two edges after the
   // edge on which it is sampled.
   task automatic push_exp(input int c);
      exp_t e;
      e.due = edge_cnt + 2;
      e.y15 = (c >= 15);
      e.y1  = (c >= 1);
      e.y29 = (c >= 29);
      e.cnt = 5'(c);
      q.push_back(e);
   endtask

   // Drive one vector just after the next rising edge.
   task automatic send(input logic [28:0] v, input int c);
      @(posedge clk);
      #1;
      vec      = v;
      in_valid = 1'b1;
      push_exp(c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   // Monitor: compare on every falling edge while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("ov_align_t1",  ov_1,  ov_15);
            check("ov_align_t29", ov_29, ov_15);
            if (ov_15) begin
               if (q.size() == 0) begin
                  check("unexpected_out_valid", ov_15, 1'b0);
               end else begin
                  e = q.pop_front();
                  check("latency", edge_cnt, e.due);
                  check("y0_t15", y_15, e.y15);
                  check("y0_t1",  y_1,  e.y1);
                  check("y0_t29", y_29, e.y29);
`ifdef TOP_COUNT_OUT_EN
                  check("cnt", cnt_15, e.cnt);
`endif
                  hold = e;
               end
            end else begin
               check("hold_t15", y_15, hold.y15);
               check("hold_t1",  y_1,  hold.y1);
               check("hold_t29", y_29, hold.y29);
`ifdef TOP_COUNT_OUT_EN
               check("hold_cnt", cnt_15, hold.cnt);
`endif
               if (q.size() > 0 && q[0].due <= edge_cnt) begin
                  check("missing_out_valid", ov_15, 1'b1);
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   logic [28:0] dvec [9];
   int          dcnt [9];

   initial begin
      logic [28:0] r;
      // Directed vectors with hand-counted ones.
      dvec[0] = 29'h0000_0000; dcnt[0] = 0;   // all zero
      dvec[1] = 29'h0000_7FFF; dcnt[1] = 15;  // x0..x14, exactly THRESH
      dvec[2] = 29'h0000_3FFF; dcnt[2] = 14;  // x0..x13, THRESH-1
      dvec[3] = 29'h1FFF_FFFF; dcnt[3] = 29;  // all ones
      dvec[4] = 29'h1FFF_C000; dcnt[4] = 15;  // x14..x28, high half
      dvec[5] = 29'h1555_5555; dcnt[5] = 15;  // x0,x2,..,x28 alternating
      dvec[6] = 29'h1000_0000; dcnt[6] = 1;   // single one on x28
      dvec[7] = 29'h0FFF_FFFF; dcnt[7] = 28;  // 28 ones, x28 clear
      dvec[8] = 29'h0000_0001; dcnt[8] = 1;   // single one on x0

      hold     = '{due: 0, y15: 1'b0, y1: 1'b0, y29: 1'b0, cnt: 5'd0};
      rst_n    = 1'b0;
      in_valid = 1'b0;
      vec      = '0;

      #3;
      check("rst_y0",        y_15,  1'b0);
      check("rst_out_valid", ov_15, 1'b0);
      check("rst_y0_t1",     y_1,   1'b0);
      check("rst_ov_t1",     ov_1,  1'b0);

      // The first vector is set up while still in reset; it must be sampled
      // on the first rising edge after release.
      @(negedge clk);
      @(negedge clk);
      vec      = dvec[0];
      in_valid = 1'b1;
      push_exp(dcnt[0]);
      rst_n    = 1'b1;

      for (int i = 1; i < 9; i++) send(dvec[i], dcnt[i]);
      idle(3);

      // Back-to-back random stream, then an idle gap to check the hold.
      for (int i = 0; i < 1000; i++) begin
         r = 29'($urandom());
         send(r, $countones(r));
      end
      idle(3);

      // Mid-operation reset: an all-ones result sets y0=1. Then two further
      // vectors are in flight when reset arrives between edges.
      send(29'h1FFF_FFFF, 29);
      send(29'h1FFF_FFFF, 29);
      send(29'h1FFF_FFFF, 29);
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      hold     = '{due: 0, y15: 1'b0, y1: 1'b0, y29: 1'b0, cnt: 5'd0};
      #1;
      check("midrst_y0",        y_15,  1'b0);
      check("midrst_out_valid", ov_15, 1'b0);
      check("midrst_y0_t1",     y_1,   1'b0);
`ifdef TOP_COUNT_OUT_EN
      check("midrst_cnt",       cnt_15, 5'd0);
`endif
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      idle(5);

      // Normal operation after the reset.
      send(dvec[1], dcnt[1]);
      send(dvec[2], dcnt[2]);
      idle(1);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
